input_link_sequencer: RTL and testbench

//  Per-bunch-crossing readout controller for NLINK input-link stub buffers.

---
 rtl/input_link_sequencer_pkg.sv | 14 +
 rtl/input_link_sequencer_if.sv | 34 +++
 rtl/input_link_sequencer_rr_arbiter.sv | 33 +++
 rtl/input_link_sequencer.sv | 115 +++++++++++
 tb/tb_input_link_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/input_link_sequencer_pkg.sv
// Shared types and constants for the input-link readout sequencer.
package input_link_sequencer_pkg;

  localparam int STUB_W        = 36;
  // Offset of the link-local payload field inside a stub word; downstream stages slice on it.
  localparam int LINK_DATA_LSB = 14;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/input_link_sequencer_if.sv
// Link-side and memory-side signals of the sequencer, bundled for port hookup.
interface input_link_sequencer_if #(
  parameter int NLINK     = 2,
  parameter int ADDR_BITS = 6,
  parameter int PAGE_BITS = 3
);
  import input_link_sequencer_pkg::*;

  logic                          en_proc;
  logic                          start;
  logic [PAGE_BITS-1:0]          bx_in;
  logic                          done;
  logic [NLINK-1:0]              link_empty;
  logic [NLINK-1:0]              link_read_en;
  logic [STUB_W*NLINK-1:0]       link_data;
  logic                          mem_we;
  logic [PAGE_BITS+ADDR_BITS-1:0] mem_addr;
  logic [STUB_W-1:0]             mem_data;
  logic [ADDR_BITS:0]            nstubs;
  logic                          overflow;

  // Environment side: drives control and link inputs, observes results.
  modport master (
    output en_proc, start, bx_in, link_empty, link_data,
    input  done, link_read_en, mem_we, mem_addr, mem_data, nstubs, overflow
  );

  // Sequencer side.
  modport slave (
    input  en_proc, start, bx_in, link_empty, link_data,
    output done, link_read_en, mem_we, mem_addr, mem_data, nstubs, overflow
  );

endinterface

// File: rtl/input_link_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module input_link_sequencer_rr_arbiter #(
  parameter int NLINK = 2,
  parameter int PTR_W = 1
) (
  input  logic [NLINK-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NLINK-1:0] o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_vld
);

  logic [2*NLINK-1:0] w_rot;
  logic [PTR_W-1:0]   w_off;
  logic [PTR_W:0]     w_sum;

  // Rotate requests so the pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    o_vld = 1'b0;
    w_off = '0;
    w_rot = {i_req, i_req} >> i_ptr;
    for (int i = NLINK - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_vld = 1'b1;
        w_off = PTR_W'(i);
      end
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    o_idx = (w_sum >= (PTR_W+1)'(NLINK)) ? PTR_W'(w_sum - (PTR_W+1)'(NLINK)) : w_sum[PTR_W-1:0];
    o_gnt = o_vld ? (NLINK'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/input_link_sequencer.sv
// Per-BX readout controller: drains input links round-robin into a paged stub memory.
module input_link_sequencer
  import input_link_sequencer_pkg::*;
#(
  parameter int NLINK     = 2,
  parameter int WINDOW    = 64,
  parameter int ADDR_BITS = 6,
  parameter int PAGE_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input_link_sequencer_if.slave bus
);

  localparam int MAXSTUBS = 2 ** ADDR_BITS;
  localparam int PTR_W    = (NLINK > 1) ? $clog2(NLINK) : 1;
  localparam int TMR_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  state_t               r_state, w_state_nxt;
  logic [PTR_W-1:0]     r_ptr, r_grant_d, w_idx, w_ptr_nxt;
  logic [TMR_W-1:0]     r_timer;
  logic [ADDR_BITS:0]   r_issued, r_count, r_nstubs;
  logic [PAGE_BITS-1:0] r_page;
  logic                 r_ovf, r_wr_vld;
  logic [NLINK-1:0]     w_gnt;
  logic                 w_vld, w_room, w_issue, w_start_ok, w_run_en, w_tmr_end;
  logic [STUB_W-1:0]    w_link [NLINK];

  for (genvar gi = 0; gi < NLINK; gi++) begin : g_split
    assign w_link[gi] = bus.link_data[gi*STUB_W +: STUB_W];
  end

  input_link_sequencer_rr_arbiter #(.NLINK(NLINK), .PTR_W(PTR_W)) u_arb (
    .i_req (~bus.link_empty),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_vld (w_vld)
  );

  // Issue gating counts reads, not writes, so a full page never receives a wrapped address.
  assign w_room     = r_issued < (ADDR_BITS+1)'(MAXSTUBS);
  assign w_start_ok = (r_state == S_IDLE) && bus.start && bus.en_proc;
  assign w_run_en   = (r_state == S_RUN) && bus.en_proc;
  assign w_issue    = w_run_en && w_vld && w_room;
  assign w_tmr_end  = r_timer == TMR_W'(WINDOW - 1);
  assign w_ptr_nxt  = (w_idx == PTR_W'(NLINK - 1)) ? '0 : w_idx + 1'b1;

  assign bus.link_read_en = w_issue ? w_gnt : '0;
  assign bus.done         = (r_state == S_DRAIN);
  assign bus.mem_we       = r_wr_vld;
  assign bus.mem_addr     = r_wr_vld ? {r_page, r_count[ADDR_BITS-1:0]} : '0;
  assign bus.mem_data     = r_wr_vld ? w_link[r_grant_d] : '0;
  assign bus.nstubs       = r_nstubs;
  assign bus.overflow     = r_ovf;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: window opens on accepted start, closes after WINDOW enabled cycles plus one drain cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (bus.en_proc && w_tmr_end) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read side: rr pointer, issued count, one-deep write pipeline stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      r_issued  <= '0;
      r_wr_vld  <= 1'b0;
      r_grant_d <= '0;
    end else begin
      r_wr_vld <= w_issue;
      if (w_start_ok)   r_issued <= '0;
      else if (w_issue) r_issued <= r_issued + 1'b1;
      if (w_issue) begin
        r_grant_d <= w_idx;
        r_ptr     <= w_ptr_nxt;
      end
    end
  end

  // Window bookkeeping: page, timer, write count, overflow flag and the published stub count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_page   <= '0;
      r_timer  <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_nstubs <= '0;
    end else if (w_start_ok) begin
      r_page  <= bus.bx_in;
      r_timer <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_wr_vld) r_count <= r_count + 1'b1;
      if (w_run_en) begin
        r_timer <= r_timer + 1'b1;
        if (w_vld && !w_room) r_ovf <= 1'b1;
      end
      if (r_state == S_DRAIN) r_nstubs <= r_count + (ADDR_BITS+1)'(r_wr_vld);
    end
  end

endmodule

// File: tb/tb_input_link_sequencer.sv
// Randomized and directed bench for input_link_sequencer with a cycle-level behavioural model.
module tb_input_link_sequencer;

  localparam int NLINK = 2, WINDOW = 20, ADDR_BITS = 3, PAGE_BITS = 3;
  localparam int SW = 36, MAXS = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  input_link_sequencer_if #(.NLINK(NLINK), .ADDR_BITS(ADDR_BITS), .PAGE_BITS(PAGE_BITS)) bus();

  input_link_sequencer #(.NLINK(NLINK), .WINDOW(WINDOW), .ADDR_BITS(ADDR_BITS), .PAGE_BITS(PAGE_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0, bad = 0, cyc = 0;
  logic [SW-1:0] srcq [NLINK][$];
  logic [SW-1:0] mq   [NLINK][$];
  logic [NLINK-1:0] re_seen = '0;

  // model of what the block must be doing
  int  m_on = 0, m_phase = 0, m_t = 0, m_issued = 0, m_wcnt = 0, m_ptr = 0, m_page = 0, m_nst = 0;
  bit  m_ovf = 0, m_pend = 0;
  logic [SW-1:0] m_pdata = '0;

  int            wlog_addr[$];
  logic [SW-1:0] wlog_data[$];
  int            done_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model with this cycle's inputs.
  always @(negedge clk) begin : p_cmp
    int g, j;
    bit any;
    logic [NLINK-1:0] ere;
    cyc++;
    g = -1;
    any = 0;
    for (int k = 0; k < NLINK; k++) if (mq[k].size() > 0) any = 1;
    if (m_phase == 1 && bus.en_proc && m_issued < MAXS)
      for (int k = 0; k < NLINK; k++) begin
        j = (m_ptr + k) % NLINK;
        if (g < 0 && mq[j].size() > 0) g = j;
      end
    ere = '0;
    if (g >= 0) ere[g] = 1'b1;
    if (m_on != 0) begin
      chk("read_en",  64'(bus.link_read_en), 64'(ere));
      chk("mem_we",   64'(bus.mem_we), 64'(m_pend));
      chk("mem_addr", 64'(bus.mem_addr), m_pend ? 64'(m_page * MAXS + m_wcnt) : 64'd0);
      chk("mem_data", 64'(bus.mem_data), m_pend ? 64'(m_pdata) : 64'd0);
      chk("done",     64'(bus.done), 64'(m_phase == 2));
      chk("nstubs",   64'(bus.nstubs), 64'(m_nst));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    end
    re_seen = bus.link_read_en;
    if (bus.mem_we === 1'b1) begin
      wlog_addr.push_back(int'(bus.mem_addr));
      wlog_data.push_back(bus.mem_data);
    end
    if (bus.done === 1'b1) done_cyc.push_back(cyc);
    if (reset) begin
      m_phase = 0; m_pend = 0; m_ptr = 0; m_ovf = 0; m_nst = 0;
      m_wcnt = 0; m_page = 0; m_issued = 0; m_t = 0; m_on = 1;
    end else if (m_on != 0) begin
      if (m_pend) begin m_wcnt++; m_pend = 0; end
      case (m_phase)
        0: if (bus.start && bus.en_proc) begin
             m_phase = 1; m_page = int'(bus.bx_in); m_wcnt = 0; m_issued = 0; m_t = 0; m_ovf = 0;
           end
        1: if (bus.en_proc) begin
             if (g >= 0) begin
               m_pdata = mq[g].pop_front(); m_pend = 1; m_issued++; m_ptr = (g + 1) % NLINK;
             end else if (m_issued == MAXS && any) m_ovf = 1;
             if (m_t == WINDOW - 1) m_phase = 2; else m_t++;
           end
        default: begin m_nst = m_wcnt; m_phase = 0; end
      endcase
    end
  end

  // One clock; registered link source pops the stub whose read_en was seen last cycle.
  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < NLINK; i++) begin
      if (re_seen[i] && srcq[i].size() > 0) bus.link_data[i*SW +: SW] = srcq[i].pop_front();
      bus.link_empty[i] = (srcq[i].size() == 0);
    end
  endtask

  task automatic push(input int l, input logic [SW-1:0] d);
    srcq[l].push_back(d);
    mq[l].push_back(d);
    bus.link_empty[l] = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < NLINK; i++) begin
      srcq[i].delete();
      mq[i].delete();
      bus.link_empty[i] = 1'b1;
    end
  endtask

  task automatic start_window(input int bx, output int s);
    bus.en_proc = 1'b1;
    bus.start   = 1'b1;
    bus.bx_in   = PAGE_BITS'(bx);
    s = cyc + 1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int nd, input int lim);
    for (int i = 0; i < lim && done_cyc.size() == nd; i++) tick();
    chk("done_seen", 64'(done_cyc.size() > nd), 64'd1);
  endtask

  function automatic int wa(input int k);
    return (k < wlog_addr.size()) ? wlog_addr[k] : -1;
  endfunction

  function automatic int dc(input int k);
    return (k < done_cyc.size()) ? done_cyc[k] : -1;
  endfunction

  // A0,A1,A2 on link0 and B0,B1 on link1 from pointer 0 must interleave as below.
  task automatic run_s1(input string tag);
    logic [SW-1:0] e1 [5];
    int s, nd, w0;
    e1 = '{36'hA00000000, 36'hB00000000, 36'hA00000001, 36'hB00000001, 36'hA00000002};
    for (int k = 0; k < 3; k++) push(0, 36'hA00000000 + 36'(k));
    for (int k = 0; k < 2; k++) push(1, 36'hB00000000 + 36'(k));
    w0 = wlog_addr.size(); nd = done_cyc.size();
    start_window(5, s);
    wait_done(nd, WINDOW + 10);
    chk({tag, "_nwr"}, 64'(wlog_addr.size() - w0), 64'd5);
    for (int k = 0; k < 5; k++) begin
      chk({tag, "_addr"}, 64'(wa(w0 + k)), 64'(40 + k));
      chk({tag, "_data"}, (w0 + k < wlog_data.size()) ? 64'(wlog_data[w0 + k]) : 64'hX, 64'(e1[k]));
    end
    chk({tag, "_done_t"}, 64'(dc(nd)), 64'(s + WINDOW + 1));
    chk({tag, "_nstubs"}, 64'(bus.nstubs), 64'd5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, nd, w0, n0, n1, sc;
    reset = 1'b1;
    bus.en_proc = 1'b0; bus.start = 1'b0; bus.bx_in = '0;
    bus.link_empty = '1; bus.link_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_re", 64'(bus.link_read_en), 64'd0);
    chk("rst_nstubs", 64'(bus.nstubs), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    tick();

    run_s1("s1");

    // empty links for the whole window
    w0 = wlog_addr.size(); nd = done_cyc.size();
    start_window(3, s);
    wait_done(nd, WINDOW + 10);
    chk("s2_nwr", 64'(wlog_addr.size() - w0), 64'd0);
    chk("s2_done_t", 64'(dc(nd)), 64'(s + WINDOW + 1));
    chk("s2_nstubs", 64'(bus.nstubs), 64'd0);
    chk("s2_ovf", 64'(bus.overflow), 64'd0);

    // 12 stubs into an 8-entry page
    for (int k = 0; k < 6; k++) begin push(0, 36'hC00000000 + 36'(k)); push(1, 36'hD00000000 + 36'(k)); end
    w0 = wlog_addr.size(); nd = done_cyc.size();
    start_window(1, s);
    wait_done(nd, WINDOW + 10);
    chk("s3_nwr", 64'(wlog_addr.size() - w0), 64'd8);
    for (int k = 0; k < 8; k++) chk("s3_addr", 64'(wa(w0 + k)), 64'(8 + k));
    chk("s3_ovf", 64'(bus.overflow), 64'd1);
    chk("s3_nstubs", 64'(bus.nstubs), 64'd8);
    flush();

    // processing frozen for 10 cycles while stubs are pending
    for (int k = 0; k < 3; k++) begin push(0, 36'hE00000000 + 36'(k)); push(1, 36'hF00000000 + 36'(k)); end
    w0 = wlog_addr.size(); nd = done_cyc.size();
    start_window(6, s);
    tick(); tick();
    bus.en_proc = 1'b0;
    repeat (10) tick();
    bus.en_proc = 1'b1;
    wait_done(nd, WINDOW + 30);
    chk("s4_done_t", 64'(dc(nd)), 64'(s + WINDOW + 11));
    chk("s4_nwr", 64'(wlog_addr.size() - w0), 64'd6);

    // reset five cycles into a window
    for (int k = 0; k < 5; k++) push(k % 2, 36'h123000000 + 36'(k));
    nd = done_cyc.size();
    start_window(5, s);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s5_we", 64'(bus.mem_we), 64'd0);
    chk("s5_re", 64'(bus.link_read_en), 64'd0);
    chk("s5_nstubs", 64'(bus.nstubs), 64'd0);
    flush();
    repeat (WINDOW + 5) tick();
    chk("s5_nodone", 64'(done_cyc.size()), 64'(nd));
    run_s1("s5b");

    // second start inside the window is ignored
    for (int k = 0; k < 3; k++) begin push(0, 36'h777000000 + 36'(k)); push(1, 36'h888000000 + 36'(k)); end
    w0 = wlog_addr.size(); nd = done_cyc.size();
    start_window(5, s);
    tick();
    bus.start = 1'b1; bus.bx_in = 3'd2;
    tick();
    bus.start = 1'b0;
    wait_done(nd, WINDOW + 10);
    repeat (WINDOW + 5) tick();
    chk("s6_ndone", 64'(done_cyc.size() - nd), 64'd1);
    chk("s6_done_t", 64'(dc(nd)), 64'(s + WINDOW + 1));
    sc = 0;
    for (int k = w0; k < wlog_addr.size(); k++) if ((wlog_addr[k] >> 3) != 5) sc++;
    chk("s6_page", 64'(sc), 64'd0);

    // random windows with random freezes and stray starts
    for (int it = 0; it < 10; it++) begin
      n0 = $urandom_range(0, 6); n1 = $urandom_range(0, 6);
      for (int k = 0; k < n0; k++) push(0, {4'h1, 32'($urandom)});
      for (int k = 0; k < n1; k++) push(1, {4'h2, 32'($urandom)});
      nd = done_cyc.size();
      start_window(int'($urandom_range(0, 7)), s);
      for (int i = 0; i < 4 * WINDOW + 40 && done_cyc.size() == nd; i++) begin
        bus.en_proc = ($urandom_range(0, 3) != 0);
        bus.start   = ($urandom_range(0, 7) == 0);
        bus.bx_in   = PAGE_BITS'($urandom_range(0, 7));
        tick();
      end
      bus.start = 1'b0; bus.en_proc = 1'b1;
      chk("rnd_done_seen", 64'(done_cyc.size() > nd), 64'd1);
      chk("rnd_nstubs", 64'(bus.nstubs), 64'((n0 + n1 > MAXS) ? MAXS : n0 + n1));
      chk("rnd_ovf", 64'(bus.overflow), 64'(n0 + n1 > MAXS));
      flush();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
